// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive decoder: PID codes, FSM states
// and the CRC5/CRC16 parameters used by the residue checks.
package usb_rx_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_TOKEN,
        ST_DATA,
        ST_HSK,
        ST_ERR
    } state_t;

    localparam logic [4:0]  CRC5_INIT     = 5'b11111;
    localparam logic [4:0]  CRC5_POLY     = 5'b00101;
    localparam logic [4:0]  CRC5_RESIDUE  = 5'b01100;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

    function automatic logic pid_check(input logic [7:0] b);
        logic known;
        case (b[3:0])
            PID_OUT, PID_IN, PID_SETUP, PID_DATA0, PID_DATA1,
            PID_ACK, PID_NAK, PID_STALL: known = 1'b1;
            default:                     known = 1'b0;
        endcase
        return known && (b[7:4] == ~b[3:0]);
    endfunction

    function automatic state_t pid_class(input logic [3:0] p);
        case (p)
            PID_OUT, PID_IN, PID_SETUP: return ST_TOKEN;
            PID_DATA0, PID_DATA1:       return ST_DATA;
            default:                    return ST_HSK;
        endcase
    endfunction

    // Look-ahead steps so end-of-packet can judge a bit arriving in the same cycle.
    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        return {c[3:0], 1'b0} ^ ({5{b ^ c[4]}} & CRC5_POLY);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ({16{b ^ c[15]}} & CRC16_POLY);
    endfunction

endpackage

// File: rtl/usb_rx_crc.sv
// Serial CRC register, MSB-feedback form, one bit per enabled cycle.
module usb_rx_crc #(
    parameter int           W    = 5,
    parameter logic [W-1:0] POLY = '0,
    parameter logic [W-1:0] INIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         bit_in,
    output logic [W-1:0] crc
);

    logic [W-1:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr)
            crc_d = INIT;
        else if (en)
            crc_d = {crc_q[W-2:0], 1'b0} ^ ({W{bit_in ^ crc_q[W-1]}} & POLY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= INIT;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_rx_decoder.sv
// USB receive packet decoder: PID check, token/data/handshake handling, CRC checks.
// Optional packet statistics counters under RX_DECODER_STATS_EN.
module usb_rx_decoder
    import usb_rx_pkg::*;
#(
    parameter int MAX_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_in,
    input  logic        bit_valid,
    input  logic        start_decode,
    input  logic        end_decode,
    output logic [3:0]  pid,
    output logic        pid_valid,
    output logic        pid_error,
    output logic [6:0]  addr,
    output logic [3:0]  endp,
    output logic [7:0]  data_byte,
    output logic        byte_valid,
    output logic        crc_error,
    output logic        pkt_done
`ifdef RX_DECODER_STATS_EN
    ,
    output logic [15:0] good_pkt_cnt,
    output logic [15:0] err_pkt_cnt
`endif
);

    localparam int BCW = $clog2(MAX_BYTES + 4);

    state_t          state_q, state_d;
    logic [9:0]      cnt_q, cnt_d;
    logic [15:0]     sr_q, sr_d, sr_shift;
    logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]      buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]      buf_cnt_q, buf_cnt_d;
    logic [3:0]      pid_q, pid_d, endp_q, endp_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      data_byte_q, data_byte_d;
    logic            pid_valid_q, pid_valid_d, pid_error_q, pid_error_d;
    logic            byte_valid_q, byte_valid_d, crc_error_q, crc_error_d;
    logic            pkt_done_q, pkt_done_d, pid_err_sent_q, pid_err_sent_d;
    logic            crc_en, crc_clr;
    logic [4:0]      crc5_q, crc5_chk;
    logic [15:0]     crc16_q, crc16_chk;

    usb_rx_crc #(.W(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT)) u_crc5 (
        .clk(clk), .rst(rst), .en(crc_en), .clr(crc_clr), .bit_in(s_in), .crc(crc5_q)
    );

    usb_rx_crc #(.W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT)) u_crc16 (
        .clk(clk), .rst(rst), .en(crc_en), .clr(crc_clr), .bit_in(s_in), .crc(crc16_q)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sr_d           = sr_q;
        byte_cnt_d     = byte_cnt_q;
        buf0_d         = buf0_q;
        buf1_d         = buf1_q;
        buf_cnt_d      = buf_cnt_q;
        pid_d          = pid_q;
        addr_d         = addr_q;
        endp_d         = endp_q;
        data_byte_d    = data_byte_q;
        pid_err_sent_d = pid_err_sent_q;
        pid_valid_d    = 1'b0;
        pid_error_d    = 1'b0;
        byte_valid_d   = 1'b0;
        crc_error_d    = 1'b0;
        pkt_done_d     = 1'b0;
        crc_en         = 1'b0;
        crc_clr        = 1'b0;
        sr_shift       = {s_in, sr_q[15:1]};
        crc5_chk       = bit_valid ? crc5_step(crc5_q, s_in) : crc5_q;
        crc16_chk      = bit_valid ? crc16_step(crc16_q, s_in) : crc16_q;

        if (start_decode) begin
            // A bit in the start cycle is the first PID bit.
            state_d        = ST_PID;
            cnt_d          = bit_valid ? 10'd1 : 10'd0;
            sr_d           = bit_valid ? {s_in, 15'd0} : 16'd0;
            byte_cnt_d     = '0;
            buf_cnt_d      = 2'd0;
            pid_err_sent_d = 1'b0;
            crc_clr        = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_PID: begin
                    if (bit_valid) begin
                        sr_d  = sr_shift;
                        cnt_d = cnt_q + 10'd1;
                    end
                    if (bit_valid && cnt_q == 10'd7) begin
                        cnt_d = 10'd0;
                        if (pid_check(sr_shift[15:8])) begin
                            pid_valid_d = 1'b1;
                            pid_d       = sr_shift[11:8];
                            state_d     = pid_class(sr_shift[11:8]);
                            if (end_decode) begin
                                state_d = ST_IDLE;
                                if (pid_class(sr_shift[11:8]) == ST_HSK) pkt_done_d  = 1'b1;
                                else                                     crc_error_d = 1'b1;
                            end
                        end else begin
                            pid_error_d    = 1'b1;
                            pid_err_sent_d = 1'b1;
                            state_d        = end_decode ? ST_IDLE : ST_ERR;
                        end
                    end else if (end_decode) begin
                        pid_error_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_TOKEN: begin
                    if (bit_valid) begin
                        crc_en = 1'b1;
                        sr_d   = sr_shift;
                        if (cnt_q != 10'h3FF) cnt_d = cnt_q + 10'd1;
                    end
                    if (end_decode) begin
                        state_d = ST_IDLE;
                        if (cnt_d == 10'd16 && crc5_chk == CRC5_RESIDUE) begin
                            addr_d     = sr_d[6:0];
                            endp_d     = sr_d[10:7];
                            pkt_done_d = 1'b1;
                        end else begin
                            crc_error_d = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_valid) begin
                        crc_en = 1'b1;
                        sr_d   = sr_shift;
                        cnt_d  = cnt_q + 10'd1;
                        if (cnt_q[2:0] == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + BCW'(1);
                            if (byte_cnt_d > BCW'(MAX_BYTES + 2)) begin
                                state_d = ST_ERR;
                            end else if (buf_cnt_q == 2'd2) begin
                                data_byte_d  = buf0_q;
                                byte_valid_d = 1'b1;
                                buf0_d       = buf1_q;
                                buf1_d       = sr_shift[15:8];
                            end else if (buf_cnt_q == 2'd1) begin
                                buf1_d    = sr_shift[15:8];
                                buf_cnt_d = 2'd2;
                            end else begin
                                buf0_d    = sr_shift[15:8];
                                buf_cnt_d = 2'd1;
                            end
                        end
                    end
                    if (end_decode) begin
                        state_d   = ST_IDLE;
                        buf_cnt_d = 2'd0;
                        if (cnt_d[2:0] == 3'd0 && byte_cnt_d >= BCW'(2) &&
                            byte_cnt_d <= BCW'(MAX_BYTES + 2) && crc16_chk == CRC16_RESIDUE)
                            pkt_done_d = 1'b1;
                        else
                            crc_error_d = 1'b1;
                    end
                end
                ST_HSK: begin
                    if (bit_valid) begin
                        state_d = ST_ERR;
                        if (end_decode) begin
                            crc_error_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    end else if (end_decode) begin
                        pkt_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (end_decode) begin
                        crc_error_d = !pid_err_sent_q;
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            sr_q           <= '0;
            byte_cnt_q     <= '0;
            buf0_q         <= '0;
            buf1_q         <= '0;
            buf_cnt_q      <= '0;
            pid_q          <= '0;
            addr_q         <= '0;
            endp_q         <= '0;
            data_byte_q    <= '0;
            pid_err_sent_q <= 1'b0;
            pid_valid_q    <= 1'b0;
            pid_error_q    <= 1'b0;
            byte_valid_q   <= 1'b0;
            crc_error_q    <= 1'b0;
            pkt_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sr_q           <= sr_d;
            byte_cnt_q     <= byte_cnt_d;
            buf0_q         <= buf0_d;
            buf1_q         <= buf1_d;
            buf_cnt_q      <= buf_cnt_d;
            pid_q          <= pid_d;
            addr_q         <= addr_d;
            endp_q         <= endp_d;
            data_byte_q    <= data_byte_d;
            pid_err_sent_q <= pid_err_sent_d;
            pid_valid_q    <= pid_valid_d;
            pid_error_q    <= pid_error_d;
            byte_valid_q   <= byte_valid_d;
            crc_error_q    <= crc_error_d;
            pkt_done_q     <= pkt_done_d;
        end
    end

    assign pid        = pid_q;
    assign pid_valid  = pid_valid_q;
    assign pid_error  = pid_error_q;
    assign addr       = addr_q;
    assign endp       = endp_q;
    assign data_byte  = data_byte_q;
    assign byte_valid = byte_valid_q;
    assign crc_error  = crc_error_q;
    assign pkt_done   = pkt_done_q;

`ifdef RX_DECODER_STATS_EN
    logic [15:0] good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d;

    always_comb begin
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (pkt_done_d && good_cnt_q != 16'hFFFF)
            good_cnt_d = good_cnt_q + 16'd1;
        if ((pid_error_d || crc_error_d) && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign good_pkt_cnt = good_cnt_q;
    assign err_pkt_cnt  = err_cnt_q;
`endif

endmodule

// File: doc/usb_rx_decoder.md
Name: usb_rx_decoder

Overview:
- Bit-stream decoder directly downstream of the bit unstuffer in the USB receive path.
- Consumes unstuffed LSB-first serial bits framed by start_decode/end_decode.
- Validates the PID, classifies the packet (token, data or handshake), extracts fields and checks CRC5 or CRC16.
- Presents results to the protocol FSM, with data bytes streamed out minus the trailing CRC bytes.

Parameters:
- MAX_BYTES, 64, maximum data payload bytes excluding the CRC16; exceeding it is an error.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- s_in  in  1  unstuffed serial bit, LSB first.
- bit_valid  in  1  s_in is valid this cycle; stuffed-bit gaps appear as bit_valid=0.
- start_decode  in  1  one-cycle pulse; the first PID bit arrives in the same cycle or later.
- end_decode  in  1  one-cycle pulse after the last bit of the packet.
- pid  out  4  decoded PID nibble; held until the next start_decode.
- pid_valid  out  1  one-cycle pulse when the PID check passes.
- pid_error  out  1  one-cycle pulse on PID check failure or truncated PID.
- addr  out  7  token address field.
- endp  out  4  token endpoint field.
- data_byte  out  8  payload byte.
- byte_valid  out  1  one-cycle pulse qualifying data_byte.
- crc_error  out  1  one-cycle pulse at end of packet on CRC or length failure.
- pkt_done  out  1  one-cycle pulse at end of a good packet.

Behaviour:
Reset:
- All outputs 0; pid=0; FSM to IDLE; shift register, bit counter and byte delay buffer cleared.
- Reset mid-packet discards the packet; no pulses are emitted.

Shifting and PID:
- A bit is consumed only when bit_valid=1 and state is not IDLE or ERR. The shift register shifts right, with the new bit entering at the MSB.
- PID check after 8 bits: byte[7:4] must equal ~byte[3:0], and byte[3:0] must be in the defined set:
  - OUT 0001, IN 1001, SETUP 1101
  - DATA0 0011, DATA1 1011
  - ACK 0010, NAK 1010, STALL 1110
- Check failure: pid_error pulses the cycle after the 8th bit, and the FSM goes to ERR.

FSM states:
- IDLE: on start_decode, go to PID. Bit counter clears.
- PID: collect 8 bits. On a good check, pid_valid pulses and pid latches. The FSM then goes to TOKEN for token PIDs, DATA for DATA0/DATA1, or HSK for handshakes. end_decode before 8 bits → pid_error, go to IDLE.
- TOKEN: collect exactly 16 bits through CRC5. At end_decode:
  - Good = bit count 16 and CRC5 residue 5'b01100. Then addr=bits[6:0], endp=bits[10:7] latched, pkt_done pulses.
  - Otherwise crc_error pulses and addr/endp are unchanged.
  - Either way, go to IDLE.
- DATA:
  - Bytes feed the CRC16 engine bitwise and assemble LSB first.
  - Each completed byte enters a 2-entry delay buffer. When the buffer already holds 2 bytes, the oldest byte is emitted on data_byte with byte_valid, so the final 2 bytes (the CRC) are never emitted.
  - At end_decode, the packet is good only if all of the following hold:
    - bit count is a multiple of 8;
    - byte count ≥ 2;
    - byte count ≤ MAX_BYTES+2;
    - CRC16 residue is 16'h800D.
  - Good → pkt_done; bad → crc_error. Go to IDLE; the buffer is flushed without emitting.
  - Byte count exceeding MAX_BYTES+2 mid-packet → go to ERR immediately; no further byte_valid.
- HSK: any valid bit → ERR. end_decode with zero extra bits → pkt_done, go to IDLE.
- ERR: swallows bits. On end_decode, crc_error pulses (unless pid_error was already issued for this packet), then go to IDLE.

Simultaneous events and latency:
- start_decode in a non-IDLE state aborts the current packet silently and restarts in PID.
- end_decode together with bit_valid: the bit is consumed first, then end-of-packet is evaluated in the same cycle.
- All output pulses are registered: one cycle after the causing input.

CRC engines:
- CRC5: init 5'b11111, polynomial 5'b00101.
- CRC16: init 16'hFFFF, polynomial 16'h8005.
- Both advance per consumed post-PID bit.

Optional Feature:
- Macro RX_DECODER_STATS_EN.
- When defined, adds 16-bit saturating outputs good_pkt_cnt and err_pkt_cnt, which increment on pkt_done and on pid_error|crc_error respectively. They reset to 0 and hold at 16'hFFFF.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package usb_rx_pkg:
  - pid_t enum holding the 8 PID codes;
  - CRC5_INIT, CRC5_POLY, CRC5_RESIDUE;
  - CRC16_INIT, CRC16_POLY, CRC16_RESIDUE;
  - decoder state enum.
- Sub-module usb_rx_crc:
  - serial CRC, parameterised by width, polynomial and init;
  - inputs: en, clr, bit;
  - output: the register value.
  - Instantiated twice: width 5 and width 16.

Test Plan:
- Token: start, then PID 8'hE1 (OUT), addr 7'h05, endp 4'h1 with correct CRC5, then end → pid_valid, pid=4'h1, pkt_done, addr=5, endp=1.
- Bad PID: byte 8'h11 → pid_error one cycle after the 8th bit; no pkt_done/crc_error on end.
- DATA0 (8'hC3) + payload 01 02 03 04 + CRC16, with random bit_valid gaps → byte_valid exactly 4 times with 01..04, then pkt_done.
- The same DATA0 packet with one payload bit flipped → 4 bytes emitted, then crc_error, no pkt_done.
- ACK (8'hD2) then end → pkt_done; ACK plus 1 extra bit → crc_error.
- Reset asserted mid-DATA, and separately start_decode mid-token → no pulses; the next clean token decodes correctly.
